// File: rtl/dct8_addr_gen.sv
// dct8_addr_gen: ping-pong RAM read/write address generator for the 4-stage 8-point memory-based DCT.
// Define DCT8_ADDR_CHECK_EN to build the {stage, index} sequence checker that drives err.
module dct8_addr_gen #(
    parameter int N         = 8,
    parameter int ADDR_W    = 3,
    parameter int PIPE_LAT  = 2,
    parameter bit BANK_INIT = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              busy_i,
    input  logic [1:0]        stage_i,
    input  logic [2:0]        index_i,
    input  logic              flush_i,
    output logic              rd_en,
    output logic [ADDR_W:0]   rd_addr,
    output logic [4:0]        coef_idx,
    output logic              wr_en,
    output logic [ADDR_W:0]   wr_addr,
    output logic              last,
    output logic              err
);

    localparam int LAST_IDX = N - 1;

    logic [ADDR_W-1:0] w_rd_off;
    logic              w_rd_bank;
    logic              w_rd_vld;
    logic              w_last_tag;

    logic              r_rd_en;
    logic [ADDR_W:0]   r_rd_addr;
    logic [4:0]        r_coef_idx;
    logic              r_rd_last;

    logic [PIPE_LAT-1:0] r_dl_vld;
    logic [PIPE_LAT-1:0] r_dl_last;
    logic [ADDR_W:0]     r_dl_addr [PIPE_LAT];

    // Stage-specific read permutation of the sample index
    always_comb begin
        w_rd_off = index_i;
        case (stage_i)
            2'd0:    w_rd_off = {index_i[2], index_i[1:0] ^ {2{index_i[2]}}};
            2'd1:    w_rd_off = {index_i[2], index_i[1], index_i[1] ^ index_i[0]};
            2'd2:    w_rd_off = {index_i[0], index_i[1], index_i[2]};
            2'd3:    w_rd_off = index_i;
            default: w_rd_off = index_i;
        endcase
    end

    assign w_rd_bank  = stage_i[0] ^ BANK_INIT;
    assign w_rd_vld   = busy_i & ~flush_i;
    assign w_last_tag = w_rd_vld & (stage_i == 2'd3) & (index_i == 3'(LAST_IDX));

    // Read-side registers; the read address holds while the controller is idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_en    <= 1'b0;
            r_rd_addr  <= {(ADDR_W+1){1'b0}};
            r_coef_idx <= 5'd0;
            r_rd_last  <= 1'b0;
        end else begin
            r_rd_en    <= w_rd_vld;
            r_rd_last  <= w_last_tag;
            r_coef_idx <= {stage_i, index_i};
            if (busy_i) begin
                r_rd_addr <= {w_rd_bank, w_rd_off};
            end else begin
                r_rd_addr <= r_rd_addr;
            end
        end
    end

    // Write delay line: entries enter with the bank already flipped; flush kills only valid/last bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dl_vld  <= {PIPE_LAT{1'b0}};
            r_dl_last <= {PIPE_LAT{1'b0}};
            for (int k = 0; k < PIPE_LAT; k++) begin
                r_dl_addr[k] <= {(ADDR_W+1){1'b0}};
            end
        end else begin
            for (int k = PIPE_LAT - 1; k > 0; k--) begin
                r_dl_addr[k] <= r_dl_addr[k-1];
            end
            r_dl_addr[0] <= {~r_rd_addr[ADDR_W], r_rd_addr[ADDR_W-1:0]};
            if (flush_i) begin
                r_dl_vld  <= {PIPE_LAT{1'b0}};
                r_dl_last <= {PIPE_LAT{1'b0}};
            end else begin
                for (int k = PIPE_LAT - 1; k > 0; k--) begin
                    r_dl_vld[k]  <= r_dl_vld[k-1];
                    r_dl_last[k] <= r_dl_last[k-1];
                end
                r_dl_vld[0]  <= r_rd_en;
                r_dl_last[0] <= r_rd_last;
            end
        end
    end

    assign rd_en    = r_rd_en;
    assign rd_addr  = r_rd_addr;
    assign coef_idx = r_coef_idx;
    assign wr_en    = r_dl_vld[PIPE_LAT-1];
    assign wr_addr  = r_dl_addr[PIPE_LAT-1];
    assign last     = r_dl_last[PIPE_LAT-1];

`ifdef DCT8_ADDR_CHECK_EN
    logic       r_chk_prev;
    logic [4:0] r_chk_next;
    logic       r_err;
    logic [4:0] w_chk_exp;
    logic       w_chk_bad;

    // A run that starts after an idle cycle must begin at {0,0}
    always_comb begin
        w_chk_exp = 5'd0;
        if (r_chk_prev) begin
            w_chk_exp = r_chk_next;
        end else begin
            w_chk_exp = 5'd0;
        end
    end

    assign w_chk_bad = busy_i & ({stage_i, index_i} != w_chk_exp);

    // Sequence tracker; the 5-bit increment wraps index into stage and stage 3 back to 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_chk_prev <= 1'b0;
            r_chk_next <= 5'd0;
            r_err      <= 1'b0;
        end else if (flush_i) begin
            r_chk_prev <= 1'b0;
            r_chk_next <= 5'd0;
            r_err      <= 1'b0;
        end else begin
            r_chk_prev <= busy_i;
            if (busy_i) begin
                r_chk_next <= {stage_i, index_i} + 5'd1;
            end else begin
                r_chk_next <= r_chk_next;
            end
            if (w_chk_bad) begin
                r_err <= 1'b1;
            end else begin
                r_err <= r_err;
            end
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_dct8_addr_gen.sv
// Randomized self-checking bench for dct8_addr_gen against a queue-based reference model.
module tb_dct8_addr_gen;

    localparam int PIPE_LAT = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       busy_i;
    logic [1:0] stage_i;
    logic [2:0] index_i;
    logic       flush_i;
    logic       rd_en;
    logic [3:0] rd_addr;
    logic [4:0] coef_idx;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic       last;
    logic       err;

    always #5 clk = ~clk;

    dct8_addr_gen #(.PIPE_LAT(PIPE_LAT)) dut (
        .clk      (clk),
        .rst      (rst),
        .busy_i   (busy_i),
        .stage_i  (stage_i),
        .index_i  (index_i),
        .flush_i  (flush_i),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .coef_idx (coef_idx),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .last     (last),
        .err      (err)
    );

    typedef struct {
        int         due;
        logic [3:0] addr;
        logic       lst;
    } wr_t;

    wr_t  inflight[$];
    int   perm1[8] = '{0, 1, 3, 2, 4, 5, 7, 6};
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   n_wr     = 0;
    int   last_cyc[$];
    logic [3:0] last_addr;

    logic       e_rd_en, e_wr_en, e_last, e_err;
    logic [3:0] e_rd_addr, e_wr_addr;
    logic [4:0] e_coef;
    bit         rd_known;
    bit         chk_prev;
    int         chk_next;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic logic [2:0] ref_offset(input int s, input int i);
        int rev;
        case (s)
            0: return (i < 4) ? 3'(i) : 3'(11 - i);
            1: return 3'(perm1[i]);
            2: begin
                rev = 0;
                for (int b = 0; b < 3; b++) if ((i >> b) % 2 == 1) rev += (1 << (2 - b));
                return 3'(rev);
            end
            default: return 3'(i);
        endcase
    endfunction

    task automatic model_reset();
        inflight.delete();
        e_rd_en = 1'b0; e_wr_en = 1'b0; e_last = 1'b0; e_err = 1'b0;
        e_rd_addr = 4'd0; e_wr_addr = 4'd0; e_coef = 5'd0;
        rd_known = 1'b1; chk_prev = 1'b0; chk_next = 0;
    endtask

    task automatic model_edge(input logic b, input int s, input int i, input logic f);
        wr_t w;
        int  want;
        if (f) inflight.delete();
        e_wr_en = 1'b0;
        e_last  = 1'b0;
        if (inflight.size() > 0 && inflight[0].due == cyc) begin
            w = inflight.pop_front();
            e_wr_en = 1'b1; e_wr_addr = w.addr; e_last = w.lst;
        end
        e_rd_en = b & ~f;
        e_coef  = {2'(s), 3'(i)};
        if (b) begin
            e_rd_addr = {1'(s % 2), ref_offset(s, i)};
            rd_known  = !f;
        end
        if (b && !f) begin
            w.due  = cyc + PIPE_LAT;
            w.addr = {1'(1 - s % 2), ref_offset(s, i)};
            w.lst  = (s == 3 && i == 7);
            inflight.push_back(w);
        end
`ifdef DCT8_ADDR_CHECK_EN
        if (f) begin
            e_err = 1'b0; chk_prev = 1'b0;
        end else if (b) begin
            want = chk_prev ? chk_next : 0;
            if (s * 8 + i != want) e_err = 1'b1;
            chk_next = (s * 8 + i + 1) % 32;
            chk_prev = 1'b1;
        end else begin
            chk_prev = 1'b0;
        end
`else
        want  = 0;
        e_err = 1'b0;
`endif
    endtask

    task automatic compare_all();
        chk("rd_en", rd_en, e_rd_en);
        chk("wr_en", wr_en, e_wr_en);
        chk("last", last, e_last);
        chk("coef_idx", coef_idx, e_coef);
        chk("err", err, e_err);
        if (rd_known) chk("rd_addr", rd_addr, e_rd_addr);
        if (e_wr_en) chk("wr_addr", wr_addr, e_wr_addr);
        if (wr_en === 1'b1) n_wr++;
        if (last === 1'b1) begin
            last_cyc.push_back(cyc);
            last_addr = wr_addr;
        end
    endtask

    task automatic step(input logic b, input int s, input int i, input logic f);
        busy_i = b; stage_i = 2'(s); index_i = 3'(i); flush_i = f;
        @(posedge clk);
        #1;
        cyc++;
        model_edge(b, s, i, f);
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, $urandom_range(0, 3), $urandom_range(0, 7), 1'b0);
    endtask

    task automatic xform();
        for (int k = 0; k < 32; k++) step(1'b1, k / 8, k % 8, 1'b0);
    endtask

    task automatic check_zero_outputs(input string pfx);
        chk({pfx, "_rd_en"}, rd_en, 0);
        chk({pfx, "_rd_addr"}, rd_addr, 0);
        chk({pfx, "_coef_idx"}, coef_idx, 0);
        chk({pfx, "_wr_en"}, wr_en, 0);
        chk({pfx, "_wr_addr"}, wr_addr, 0);
        chk({pfx, "_last"}, last, 0);
        chk({pfx, "_err"}, err, 0);
    endtask

    int wr0, lc0, gap;
    bit ab, fl;

    initial begin
        rst = 1'b1; busy_i = 1'b0; stage_i = 2'd0; index_i = 3'd0; flush_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        idle(20);

        // Single full transform
        wr0 = n_wr; lc0 = last_cyc.size();
        xform();
        idle(PIPE_LAT + 2);
        chk("full_writes", n_wr - wr0, 32);
        chk("full_lasts", last_cyc.size() - lc0, 1);
        chk("last_wr_addr", last_addr, 4'b0111);

        // Back-to-back with one idle cycle between transforms
        wr0 = n_wr; lc0 = last_cyc.size();
        xform();
        idle(1);
        xform();
        idle(PIPE_LAT + 2);
        chk("b2b_writes", n_wr - wr0, 64);
        chk("b2b_lasts", last_cyc.size() - lc0, 2);
        if (last_cyc.size() - lc0 == 2) chk("b2b_last_gap", last_cyc[lc0 + 1] - last_cyc[lc0], 33);

        // Flush together with busy at stage 1, index 5
        wr0 = n_wr; lc0 = last_cyc.size();
        for (int k = 0; k < 13; k++) step(1'b1, k / 8, k % 8, 1'b0);
        step(1'b1, 1, 5, 1'b1);
        idle(PIPE_LAT + 3);
        chk("flush_writes", n_wr - wr0, 11);
        chk("flush_lasts", last_cyc.size() - lc0, 0);

        // Asynchronous reset in stage 2, index 3
        for (int k = 0; k < 20; k++) step(1'b1, k / 8, k % 8, 1'b0);
        busy_i = 1'b0;
        rst = 1'b1;
        #1;
        check_zero_outputs("midrst");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        wr0 = n_wr;
        idle(PIPE_LAT + 2);
        chk("midrst_writes", n_wr - wr0, 0);

        // Index jump 2 -> 4 in stage 0
        step(1'b1, 0, 0, 1'b0);
        step(1'b1, 0, 1, 1'b0);
        step(1'b1, 0, 2, 1'b0);
        step(1'b1, 0, 4, 1'b0);
        step(1'b1, 0, 5, 1'b0);
        idle(3);
        step(1'b0, 0, 0, 1'b1);
        idle(PIPE_LAT + 1);

        // Randomized transforms, gaps and aborts
        for (int t = 0; t < 10; t++) begin
            gap = $urandom_range(0, 3);
            ab  = 1'b0;
            for (int k = 0; k < 32 && !ab; k++) begin
                fl = ($urandom_range(0, 63) == 0);
                step(1'b1, k / 8, k % 8, fl);
                ab = fl;
            end
            for (int g = 0; g < gap; g++) step(1'b0, $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 15) == 0);
        end
        idle(PIPE_LAT + 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
